// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order commit of out-of-order writebacks, store gating, branch
// mispredict flush. Define ROB_DUAL_COMMIT_EN to retire two register writers per cycle.
module reorder_buffer #(
   parameter int DEPTH = 16,
   parameter int ID_W  = $clog2(DEPTH)
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            rdy_in,
   input  logic            issue_valid,
   input  logic [1:0]      issue_type,
   input  logic [4:0]      issue_rd,
   input  logic [31:0]     issue_val,
   input  logic [31:0]     issue_pred,
   output logic [ID_W-1:0] alloc_id,
   output logic            full,
   input  logic            wb0_valid,
   input  logic [ID_W-1:0] wb0_id,
   input  logic [31:0]     wb0_val,
   input  logic            wb1_valid,
   input  logic [ID_W-1:0] wb1_id,
   input  logic [31:0]     wb1_val,
   output logic            store_go,
   output logic            flush,
   output logic [31:0]     flush_pc,
   output logic            commit0_valid,
   output logic [ID_W-1:0] commit0_id,
   output logic [4:0]      commit0_rd,
   output logic [31:0]     commit0_val,
   output logic            commit1_valid,
   output logic [ID_W-1:0] commit1_id,
   output logic [4:0]      commit1_rd,
   output logic [31:0]     commit1_val,
   input  logic [ID_W-1:0] q1_id,
   output logic            q1_ready,
   output logic [31:0]     q1_val,
   input  logic [ID_W-1:0] q2_id,
   output logic            q2_ready,
   output logic [31:0]     q2_val,
   output logic            jalr_pending
);
   localparam int CNT_W = ID_W + 1;
   localparam logic [1:0]       T_BR     = 2'd0;
   localparam logic [1:0]       T_ST     = 2'd1;
   localparam logic [1:0]       T_JALR   = 2'd2;
   localparam logic [1:0]       T_RG     = 2'd3;
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [ID_W-1:0]  ID_ZERO  = ID_W'(0);
   localparam logic [ID_W-1:0]  ID_ONE   = ID_W'(1);

   function automatic logic writes_reg(input logic [1:0] t);
      return (t == T_RG) || (t == T_JALR);
   endfunction

   logic [ID_W-1:0]  head_r, tail_r;
   logic [CNT_W-1:0] count_r, jalr_cnt_r;
   logic [DEPTH-1:0] done_r;
   logic [31:0]      val_r  [DEPTH];
   logic [31:0]      pred_r [DEPTH];
   logic [1:0]       type_r [DEPTH];
   logic [4:0]       rd_r   [DEPTH];
   logic             store_go_r, flush_r, commit0_valid_r;
   logic [31:0]      flush_pc_r, commit0_val_r;
   logic [ID_W-1:0]  commit0_id_r;
   logic [4:0]       commit0_rd_r;

   logic             full_s, issue_acc_s, commit0_s, commit1_s, mispred_s;
   logic             new_head_s, nxt_done_s, store_go_nxt_s;
   logic [1:0]       nxt_type_s;
   logic [ID_W-1:0]  head1_s, head_nxt_s;
   logic [CNT_W-1:0] n_commit_s, count_nxt_s, jalr_dec_s, jalr_nxt_s;

   // Next-state decode: accept, commit, mispredict and the look-ahead for store_go.
   always_comb begin
      full_s      = (count_r == CNT_FULL);
      issue_acc_s = issue_valid && !full_s && !flush_r;
      head1_s     = head_r + ID_ONE;
      commit0_s   = !flush_r && (count_r != CNT_ZERO) && done_r[head_r];
      commit1_s   = 1'b0;
`ifdef ROB_DUAL_COMMIT_EN
      commit1_s   = commit0_s && (count_r >= CNT_TWO) && done_r[head1_s] &&
                    writes_reg(type_r[head_r]) && writes_reg(type_r[head1_s]);
`endif
      mispred_s   = commit0_s && (type_r[head_r] == T_BR) && (val_r[head_r] != pred_r[head_r]);
      n_commit_s  = (commit0_s ? CNT_ONE : CNT_ZERO) + (commit1_s ? CNT_ONE : CNT_ZERO);
      head_nxt_s  = head_r + n_commit_s[ID_W-1:0];
      count_nxt_s = count_r + (issue_acc_s ? CNT_ONE : CNT_ZERO) - n_commit_s;
      jalr_dec_s  = ((commit0_s && (type_r[head_r] == T_JALR)) ? CNT_ONE : CNT_ZERO) +
                    ((commit1_s && (type_r[head1_s] == T_JALR)) ? CNT_ONE : CNT_ZERO);
      jalr_nxt_s  = jalr_cnt_r + ((issue_acc_s && (issue_type == T_JALR)) ? CNT_ONE : CNT_ZERO)
                    - jalr_dec_s;
      // The next head may be the entry being allocated right now (empty buffer case).
      new_head_s  = issue_acc_s && (tail_r == head_nxt_s);
      nxt_type_s  = new_head_s ? issue_type : type_r[head_nxt_s];
      nxt_done_s  = new_head_s ? 1'b0 :
                    (done_r[head_nxt_s] || (wb0_valid && (wb0_id == head_nxt_s)) ||
                     (wb1_valid && (wb1_id == head_nxt_s)));
      store_go_nxt_s = (count_nxt_s != CNT_ZERO) && (nxt_type_s == T_ST) && !nxt_done_s;
   end

   // Operand lookup with same-cycle writeback bypass, wb1 taking priority.
   always_comb begin
      q1_ready = done_r[q1_id];
      q1_val   = done_r[q1_id] ? val_r[q1_id] : 32'h0000_0000;
      q2_ready = done_r[q2_id];
      q2_val   = done_r[q2_id] ? val_r[q2_id] : 32'h0000_0000;
      if (wb1_valid && (wb1_id == q1_id)) begin
         q1_ready = 1'b1;
         q1_val   = wb1_val;
      end else if (wb0_valid && (wb0_id == q1_id)) begin
         q1_ready = 1'b1;
         q1_val   = wb0_val;
      end else begin
         q1_ready = done_r[q1_id];
      end
      if (wb1_valid && (wb1_id == q2_id)) begin
         q2_ready = 1'b1;
         q2_val   = wb1_val;
      end else if (wb0_valid && (wb0_id == q2_id)) begin
         q2_ready = 1'b1;
         q2_val   = wb0_val;
      end else begin
         q2_ready = done_r[q2_id];
      end
   end

   // Payload storage; issue is written last so it overrides a same-entry writeback.
   always_ff @(posedge clk_in) begin
      if (rdy_in && !flush_r) begin
         if (wb0_valid) val_r[wb0_id] <= wb0_val;
         if (wb1_valid) val_r[wb1_id] <= wb1_val;
         if (issue_acc_s) begin
            val_r[tail_r]  <= issue_val;
            pred_r[tail_r] <= issue_pred;
            type_r[tail_r] <= issue_type;
            rd_r[tail_r]   <= issue_rd;
         end
      end
   end

   // Control state and registered outputs.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         head_r <= ID_ZERO;  tail_r <= ID_ZERO;
         count_r <= CNT_ZERO;  jalr_cnt_r <= CNT_ZERO;
         done_r <= {DEPTH{1'b0}};
         store_go_r <= 1'b0;  flush_r <= 1'b0;  flush_pc_r <= 32'h0000_0000;
         commit0_valid_r <= 1'b0;  commit0_id_r <= ID_ZERO;
         commit0_rd_r <= 5'd0;  commit0_val_r <= 32'h0000_0000;
      end else if (rdy_in) begin
         if (flush_r) begin
            head_r <= ID_ZERO;  tail_r <= ID_ZERO;
            count_r <= CNT_ZERO;  jalr_cnt_r <= CNT_ZERO;
            done_r <= {DEPTH{1'b0}};
            store_go_r <= 1'b0;  flush_r <= 1'b0;  flush_pc_r <= 32'h0000_0000;
            commit0_valid_r <= 1'b0;  commit0_id_r <= ID_ZERO;
            commit0_rd_r <= 5'd0;  commit0_val_r <= 32'h0000_0000;
         end else begin
            if (wb0_valid) done_r[wb0_id] <= 1'b1;
            if (wb1_valid) done_r[wb1_id] <= 1'b1;
            if (issue_acc_s) done_r[tail_r] <= 1'b0;
            head_r     <= head_nxt_s;
            tail_r     <= tail_r + (issue_acc_s ? ID_ONE : ID_ZERO);
            count_r    <= count_nxt_s;
            jalr_cnt_r <= jalr_nxt_s;
            store_go_r <= store_go_nxt_s;
            flush_r    <= mispred_s;
            flush_pc_r <= mispred_s ? val_r[head_r] : 32'h0000_0000;
            commit0_valid_r <= commit0_s && writes_reg(type_r[head_r]);
            commit0_id_r    <= (commit0_s && writes_reg(type_r[head_r])) ? head_r : ID_ZERO;
            commit0_rd_r    <= (commit0_s && writes_reg(type_r[head_r])) ? rd_r[head_r] : 5'd0;
            commit0_val_r   <= (commit0_s && writes_reg(type_r[head_r])) ? val_r[head_r] : 32'h0000_0000;
         end
      end
   end

`ifdef ROB_DUAL_COMMIT_EN
   logic            commit1_valid_r;
   logic [ID_W-1:0] commit1_id_r;
   logic [4:0]      commit1_rd_r;
   logic [31:0]     commit1_val_r;

   // Second commit port registers.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         commit1_valid_r <= 1'b0;  commit1_id_r <= ID_ZERO;
         commit1_rd_r <= 5'd0;  commit1_val_r <= 32'h0000_0000;
      end else if (rdy_in) begin
         commit1_valid_r <= commit1_s;
         commit1_id_r    <= commit1_s ? head1_s : ID_ZERO;
         commit1_rd_r    <= commit1_s ? rd_r[head1_s] : 5'd0;
         commit1_val_r   <= commit1_s ? val_r[head1_s] : 32'h0000_0000;
      end
   end

   assign commit1_valid = commit1_valid_r;
   assign commit1_id    = commit1_id_r;
   assign commit1_rd    = commit1_rd_r;
   assign commit1_val   = commit1_val_r;
`else
   assign commit1_valid = 1'b0;
   assign commit1_id    = ID_ZERO;
   assign commit1_rd    = 5'd0;
   assign commit1_val   = 32'h0000_0000;
`endif

   assign alloc_id      = tail_r;
   assign full          = full_s;
   assign jalr_pending  = (jalr_cnt_r != CNT_ZERO);
   assign store_go      = store_go_r;
   assign flush         = flush_r;
   assign flush_pc      = flush_pc_r;
   assign commit0_valid = commit0_valid_r;
   assign commit0_id    = commit0_id_r;
   assign commit0_rd    = commit0_rd_r;
   assign commit0_val   = commit0_val_r;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed, table-driven bench for reorder_buffer (DEPTH=16) plus hand-written
// sequences for full, flush, store gating, bypass, dual commit and async reset.
module tb_reorder_buffer;
   logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1;
   logic        issue_valid;
   logic [1:0]  issue_type;
   logic [4:0]  issue_rd;
   logic [31:0] issue_val, issue_pred;
   logic [3:0]  alloc_id;
   logic        full;
   logic        wb0_valid, wb1_valid;
   logic [3:0]  wb0_id, wb1_id;
   logic [31:0] wb0_val, wb1_val;
   logic        store_go, flush;
   logic [31:0] flush_pc;
   logic        commit0_valid, commit1_valid;
   logic [3:0]  commit0_id, commit1_id;
   logic [4:0]  commit0_rd, commit1_rd;
   logic [31:0] commit0_val, commit1_val;
   logic [3:0]  q1_id, q2_id;
   logic        q1_ready, q2_ready;
   logic [31:0] q1_val, q2_val;
   logic        jalr_pending;

   int n_chk = 0;
   int n_fail = 0;

   reorder_buffer dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
      .issue_val(issue_val), .issue_pred(issue_pred),
      .alloc_id(alloc_id), .full(full),
      .wb0_valid(wb0_valid), .wb0_id(wb0_id), .wb0_val(wb0_val),
      .wb1_valid(wb1_valid), .wb1_id(wb1_id), .wb1_val(wb1_val),
      .store_go(store_go), .flush(flush), .flush_pc(flush_pc),
      .commit0_valid(commit0_valid), .commit0_id(commit0_id),
      .commit0_rd(commit0_rd), .commit0_val(commit0_val),
      .commit1_valid(commit1_valid), .commit1_id(commit1_id),
      .commit1_rd(commit1_rd), .commit1_val(commit1_val),
      .q1_id(q1_id), .q1_ready(q1_ready), .q1_val(q1_val),
      .q2_id(q2_id), .q2_ready(q2_ready), .q2_val(q2_val),
      .jalr_pending(jalr_pending)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic rdy; logic iv; logic [1:0] it; logic [4:0] ird; logic [31:0] ipred;
      logic w0v; logic [3:0] w0id; logic [31:0] w0val;
      logic w1v; logic [3:0] w1id; logic [31:0] w1val;
      logic [3:0] e_alloc; logic e_full; logic e_sgo; logic e_c0v;
      logic [3:0] e_c0id; logic [4:0] e_c0rd; logic [31:0] e_c0val;
      logic e_fl; logic e_jp;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clr();
      issue_valid = 1'b0; issue_type = 2'd3; issue_rd = 5'd0;
      issue_val = 32'hDEAD_BEEF; issue_pred = 32'h0;
      wb0_valid = 1'b0; wb0_id = 4'd0; wb0_val = 32'h0;
      wb1_valid = 1'b0; wb1_id = 4'd0; wb1_val = 32'h0;
      rdy_in = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      clr();
      rst_in = 1'b0;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
   endtask

   task automatic iss(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pred);
      clr();
      issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_pred = pred;
      tick();
   endtask

   initial begin
      // rdy iv it rd pred | w0v id val | w1v id val | alloc full sgo c0v c0id c0rd c0val fl jp
      vecs[0]  = '{1'b1,1'b1,2'd3,5'd5,32'h0,  1'b0,4'd0,32'h0,   1'b0,4'd0,32'h0,  4'd1,1'b0,1'b0,1'b0,4'd0,5'd0,32'h0,  1'b0,1'b0};
      vecs[1]  = '{1'b1,1'b0,2'd0,5'd0,32'h0,  1'b1,4'd0,32'h11,  1'b0,4'd0,32'h0,  4'd1,1'b0,1'b0,1'b0,4'd0,5'd0,32'h0,  1'b0,1'b0};
      vecs[2]  = '{1'b1,1'b0,2'd0,5'd0,32'h0,  1'b0,4'd0,32'h0,   1'b0,4'd0,32'h0,  4'd1,1'b0,1'b0,1'b1,4'd0,5'd5,32'h11, 1'b0,1'b0};
      vecs[3]  = '{1'b1,1'b1,2'd2,5'd1,32'h0,  1'b0,4'd0,32'h0,   1'b0,4'd0,32'h0,  4'd2,1'b0,1'b0,1'b0,4'd0,5'd0,32'h0,  1'b0,1'b1};
      vecs[4]  = '{1'b1,1'b1,2'd1,5'd0,32'h0,  1'b1,4'd1,32'h200, 1'b0,4'd0,32'h0,  4'd3,1'b0,1'b0,1'b0,4'd0,5'd0,32'h0,  1'b0,1'b1};
      vecs[5]  = '{1'b1,1'b0,2'd0,5'd0,32'h0,  1'b0,4'd0,32'h0,   1'b0,4'd0,32'h0,  4'd3,1'b0,1'b1,1'b1,4'd1,5'd1,32'h200,1'b0,1'b0};
      vecs[6]  = '{1'b1,1'b0,2'd0,5'd0,32'h0,  1'b0,4'd0,32'h0,   1'b1,4'd2,32'h55, 4'd3,1'b0,1'b0,1'b0,4'd0,5'd0,32'h0,  1'b0,1'b0};
      vecs[7]  = '{1'b1,1'b0,2'd0,5'd0,32'h0,  1'b0,4'd0,32'h0,   1'b0,4'd0,32'h0,  4'd3,1'b0,1'b0,1'b0,4'd0,5'd0,32'h0,  1'b0,1'b0};
      vecs[8]  = '{1'b1,1'b1,2'd0,5'd0,32'h40, 1'b0,4'd0,32'h0,   1'b0,4'd0,32'h0,  4'd4,1'b0,1'b0,1'b0,4'd0,5'd0,32'h0,  1'b0,1'b0};
      vecs[9]  = '{1'b1,1'b0,2'd0,5'd0,32'h0,  1'b1,4'd3,32'h40,  1'b0,4'd0,32'h0,  4'd4,1'b0,1'b0,1'b0,4'd0,5'd0,32'h0,  1'b0,1'b0};
      vecs[10] = '{1'b1,1'b0,2'd0,5'd0,32'h0,  1'b0,4'd0,32'h0,   1'b0,4'd0,32'h0,  4'd4,1'b0,1'b0,1'b0,4'd0,5'd0,32'h0,  1'b0,1'b0};
      vecs[11] = '{1'b1,1'b1,2'd3,5'd7,32'h0,  1'b0,4'd0,32'h0,   1'b0,4'd0,32'h0,  4'd5,1'b0,1'b0,1'b0,4'd0,5'd0,32'h0,  1'b0,1'b0};
      vecs[12] = '{1'b1,1'b0,2'd0,5'd0,32'h0,  1'b1,4'd4,32'hA,   1'b1,4'd4,32'hB,  4'd5,1'b0,1'b0,1'b0,4'd0,5'd0,32'h0,  1'b0,1'b0};
      vecs[13] = '{1'b1,1'b0,2'd0,5'd0,32'h0,  1'b0,4'd0,32'h0,   1'b0,4'd0,32'h0,  4'd5,1'b0,1'b0,1'b1,4'd4,5'd7,32'hB,  1'b0,1'b0};
      vecs[14] = '{1'b0,1'b1,2'd3,5'd9,32'h0,  1'b0,4'd0,32'h0,   1'b0,4'd0,32'h0,  4'd5,1'b0,1'b0,1'b1,4'd4,5'd7,32'hB,  1'b0,1'b0};
      vecs[15] = '{1'b1,1'b0,2'd0,5'd0,32'h0,  1'b0,4'd0,32'h0,   1'b0,4'd0,32'h0,  4'd5,1'b0,1'b0,1'b0,4'd0,5'd0,32'h0,  1'b0,1'b0};

      q1_id = 4'd0; q2_id = 4'd0;
      do_reset();
      chk("reset_alloc", 32'(alloc_id), 32'd0);
      chk("reset_full", 32'(full), 32'd0);
      chk("reset_sgo", 32'(store_go), 32'd0);
      chk("reset_c0v", 32'(commit0_valid), 32'd0);

      for (int i = 0; i < 16; i++) begin
         clr();
         rdy_in = vecs[i].rdy;
         issue_valid = vecs[i].iv; issue_type = vecs[i].it;
         issue_rd = vecs[i].ird; issue_pred = vecs[i].ipred;
         wb0_valid = vecs[i].w0v; wb0_id = vecs[i].w0id; wb0_val = vecs[i].w0val;
         wb1_valid = vecs[i].w1v; wb1_id = vecs[i].w1id; wb1_val = vecs[i].w1val;
         tick();
         chk($sformatf("v%0d_alloc", i), 32'(alloc_id), 32'(vecs[i].e_alloc));
         chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].e_full));
         chk($sformatf("v%0d_sgo", i), 32'(store_go), 32'(vecs[i].e_sgo));
         chk($sformatf("v%0d_c0v", i), 32'(commit0_valid), 32'(vecs[i].e_c0v));
         chk($sformatf("v%0d_c0id", i), 32'(commit0_id), 32'(vecs[i].e_c0id));
         chk($sformatf("v%0d_c0rd", i), 32'(commit0_rd), 32'(vecs[i].e_c0rd));
         chk($sformatf("v%0d_c0val", i), commit0_val, vecs[i].e_c0val);
         chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].e_fl));
         chk($sformatf("v%0d_jp", i), 32'(jalr_pending), 32'(vecs[i].e_jp));
      end

      // Same-cycle writeback bypass on the operand lookups.
      do_reset();
      for (int i = 0; i < 4; i++) iss(2'd3, 5'(i + 1), 32'h0);
      clr();
      wb0_valid = 1'b1; wb0_id = 4'd3; wb0_val = 32'hAA; q1_id = 4'd3; q2_id = 4'd2;
      #1;
      chk("byp_q1_ready", 32'(q1_ready), 32'd1);
      chk("byp_q1_val", q1_val, 32'hAA);
      chk("byp_q2_ready", 32'(q2_ready), 32'd0);
      chk("byp_q2_val", q2_val, 32'h0);
      wb1_valid = 1'b1; wb1_id = 4'd3; wb1_val = 32'hBB;
      #1;
      chk("byp_wb1_prio", q1_val, 32'hBB);
      tick();
      clr();
      #1;
      chk("reg_q1_ready", 32'(q1_ready), 32'd1);
      chk("reg_q1_val", q1_val, 32'hBB);

      // Fill to DEPTH, overflow ignored, freed slot not reusable on the same edge.
      do_reset();
      for (int i = 0; i < 16; i++) iss(2'd3, 5'd1, 32'h0);
      chk("full_after16", 32'(full), 32'd1);
      chk("full_alloc_wrap", 32'(alloc_id), 32'd0);
      iss(2'd3, 5'd1, 32'h0);
      chk("full_17th_full", 32'(full), 32'd1);
      chk("full_17th_alloc", 32'(alloc_id), 32'd0);
      clr(); wb0_valid = 1'b1; wb0_id = 4'd0; wb0_val = 32'h1;
      tick();
      iss(2'd3, 5'd1, 32'h0);
      chk("free_same_c0v", 32'(commit0_valid), 32'd1);
      chk("free_same_full", 32'(full), 32'd0);
      chk("free_same_alloc", 32'(alloc_id), 32'd0);
      iss(2'd3, 5'd1, 32'h0);
      chk("free_next_alloc", 32'(alloc_id), 32'd1);
      chk("free_next_full", 32'(full), 32'd1);

      // Branch mispredict: one-cycle flush, then everything cleared.
      do_reset();
      iss(2'd0, 5'd0, 32'h100);
      iss(2'd3, 5'd2, 32'h0);
      clr(); wb0_valid = 1'b1; wb0_id = 4'd0; wb0_val = 32'h104;
      tick();
      clr();
      tick();
      chk("flush_hi", 32'(flush), 32'd1);
      chk("flush_pc", flush_pc, 32'h104);
      clr(); issue_valid = 1'b1; wb0_valid = 1'b1; wb0_id = 4'd1; wb0_val = 32'h7;
      tick();
      chk("flush_lo", 32'(flush), 32'd0);
      chk("flush_pc_lo", flush_pc, 32'h0);
      chk("flush_alloc", 32'(alloc_id), 32'd0);
      chk("flush_full", 32'(full), 32'd0);
      clr();
      tick();
      chk("flush_no_commit", 32'(commit0_valid), 32'd0);
      iss(2'd3, 5'd3, 32'h0);
      chk("post_flush_issue", 32'(alloc_id), 32'd1);

      // Store into an empty buffer.
      do_reset();
      iss(2'd1, 5'd0, 32'h0);
      chk("st_go_hi", 32'(store_go), 32'd1);
      clr(); wb1_valid = 1'b1; wb1_id = 4'd0; wb1_val = 32'h0;
      tick();
      chk("st_go_lo", 32'(store_go), 32'd0);
      clr();
      tick();
      chk("st_commit_c0v", 32'(commit0_valid), 32'd0);
      chk("st_commit_sgo", 32'(store_go), 32'd0);

      // Two completed register writers at the head.
      do_reset();
      iss(2'd3, 5'd5, 32'h0);
      iss(2'd3, 5'd6, 32'h0);
      clr();
      wb0_valid = 1'b1; wb0_id = 4'd0; wb0_val = 32'h7;
      wb1_valid = 1'b1; wb1_id = 4'd1; wb1_val = 32'h9;
      tick();
      clr();
      tick();
      chk("dual_c0v", 32'(commit0_valid), 32'd1);
      chk("dual_c0rd", 32'(commit0_rd), 32'd5);
      chk("dual_c0val", commit0_val, 32'h7);
`ifdef ROB_DUAL_COMMIT_EN
      chk("dual_c1v", 32'(commit1_valid), 32'd1);
      chk("dual_c1rd", 32'(commit1_rd), 32'd6);
      chk("dual_c1val", commit1_val, 32'h9);
      tick();
      chk("dual_next_c0v", 32'(commit0_valid), 32'd0);
`else
      chk("single_c1v", 32'(commit1_valid), 32'd0);
      tick();
      chk("single_next_c0v", 32'(commit0_valid), 32'd1);
      chk("single_next_c0rd", 32'(commit0_rd), 32'd6);
      chk("single_next_c0val", commit0_val, 32'h9);
      chk("single_next_c1v", 32'(commit1_valid), 32'd0);
`endif

      // Asynchronous reset in the middle of a stream.
      do_reset();
      iss(2'd1, 5'd0, 32'h0);
      iss(2'd2, 5'd1, 32'h0);
      for (int i = 0; i < 6; i++) iss(2'd3, 5'(i + 2), 32'h0);
      clr();
      chk("mid_pre_alloc", 32'(alloc_id), 32'd8);
      chk("mid_pre_jp", 32'(jalr_pending), 32'd1);
      chk("mid_pre_sgo", 32'(store_go), 32'd1);
      #3 rst_in = 1'b0;
      #1;
      chk("mid_rst_alloc", 32'(alloc_id), 32'd0);
      chk("mid_rst_jp", 32'(jalr_pending), 32'd0);
      chk("mid_rst_sgo", 32'(store_go), 32'd0);
      chk("mid_rst_full", 32'(full), 32'd0);
      chk("mid_rst_flush", 32'(flush), 32'd0);
      chk("mid_rst_c0v", 32'(commit0_valid), 32'd0);
      @(negedge clk_in);
      rst_in = 1'b1;
      iss(2'd3, 5'd1, 32'h0);
      chk("rel_first_issue", 32'(alloc_id), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
